// File: rtl/fifo_rr_drain_if.sv
`default_nettype none
// ============================================================================
// fifo_rr_drain_if : source/destination FIFO bundle for the round-robin drain
// Revision 1.0
// ============================================================================
interface fifo_rr_drain_if #(
  parameter int DATA_WIDTH = 10
);
  logic                      enable;
  logic [3:0]                src_mask;
  logic [3:0]                src_empty;
  logic [4*DATA_WIDTH-1:0]   src_data;
  logic [3:0]                src_pop;
  logic                      dst_full;
  logic                      dst_push;
  logic [DATA_WIDTH-1:0]     dst_data;
  logic [1:0]                grant;
  logic                      busy;
  logic [15:0]               xfer_count;

  modport master (
    input  enable, src_mask, src_empty, src_data, dst_full,
    output src_pop, dst_push, dst_data, grant, busy, xfer_count
  );

  modport slave (
    output enable, src_mask, src_empty, src_data, dst_full,
    input  src_pop, dst_push, dst_data, grant, busy, xfer_count
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rr_drain.sv
`default_nettype none
// ============================================================================
// fifo_rr_drain : burst-limited round-robin mover, 4 source FIFOs -> 1 dest FIFO
// Revision 1.0
// ============================================================================
module fifo_rr_drain #(
  parameter int DATA_WIDTH = 10,
  parameter int BURST      = 2
) (
  input wire             clk,
  input wire             reset,
  fifo_rr_drain_if.master bus
);
  localparam logic [2:0] BURST_MAX = 3'(BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    PUSH = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            grant;
  logic [1:0]            grant_next;
  logic [2:0]            burst_cnt;
  logic [2:0]            burst_next;
  logic [DATA_WIDTH-1:0] out_data;
  logic [15:0]           count;

  logic [3:0]            eligible;
  logic                  go;
  logic                  keep;
  logic                  found;
  logic [1:0]            winner;
  logic [1:0]            idx;
  logic [DATA_WIDTH-1:0] src_word;

  assign eligible = bus.src_mask & ~bus.src_empty;
  assign go       = bus.enable & (|eligible) & ~bus.dst_full;
  assign src_word = bus.src_data[32'(grant)*DATA_WIDTH +: DATA_WIDTH];

  // Search starts one past the current grant; the fourth step wraps onto grant itself.
  always_comb begin
    keep   = (burst_cnt != 3'd0) && (burst_cnt < BURST_MAX) && eligible[grant];
    winner = grant;
    found  = 1'b0;
    idx    = grant;
    for (int k = 1; k <= 4; k++) begin
      idx = grant + 2'(k);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    burst_next = burst_cnt;
    case (state)
      IDLE, PUSH: begin
        state_next = IDLE;
        if (go) begin
          state_next = POP;
          if (keep) begin
            burst_next = burst_cnt + 3'd1;
          end else begin
            grant_next = winner;
            burst_next = 3'd1;
          end
        end
      end
      POP:     state_next = WAIT;
      WAIT:    state_next = PUSH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= 2'd3;
      burst_cnt <= 3'd0;
      out_data  <= '0;
      count     <= 16'd0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      burst_cnt <= burst_next;
      if (state == WAIT) begin
        out_data <= src_word;
      end
      if (state == PUSH) begin
        count <= count + 16'd1;
      end
    end
  end

  assign bus.src_pop    = (state == POP) ? (4'b0001 << grant) : 4'b0000;
  assign bus.dst_push   = (state == PUSH);
  assign bus.busy       = (state != IDLE);
  assign bus.grant      = grant;
  assign bus.dst_data   = out_data;
  assign bus.xfer_count = count;
endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_drain.sv
`default_nettype none
// ============================================================================
// tb_fifo_rr_drain : source-FIFO model plus ordered scoreboard on the destination
// Revision 1.0
// ============================================================================
module tb_fifo_rr_drain;
  localparam int DW = 10;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [DW-1:0] srcq[4][$];
  logic [DW-1:0] expq[$];

  fifo_rr_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rr_drain #(.DATA_WIDTH(DW), .BURST(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered-read source FIFOs: a pop seen in cycle k presents its word for cycle k+1.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.src_pop[i] === 1'b1) begin
        check("pop_nonempty", 32'(srcq[i].size() != 0), 32'd1);
        if (srcq[i].size() != 0) bus.src_data[i*DW +: DW] = srcq[i].pop_front();
      end
    end
    if (reset && bus.src_pop !== 4'b0000)
      check("pop_mask", 32'(bus.src_pop & bus.src_mask), 32'(bus.src_pop));
    for (int i = 0; i < 4; i++) bus.src_empty[i] = (srcq[i].size() == 0);
    if (bus.dst_push === 1'b1) begin
      check("push_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) check("push_data", 32'(bus.dst_data), 32'(expq.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    int npop;
    logic [3:0] exp_pop;
    n_tests = 0;
    n_fail  = 0;

    // Reset with random control inputs
    reset          = 1'b0;
    bus.enable     = 1'($urandom);
    bus.src_mask   = 4'($urandom);
    bus.dst_full   = 1'($urandom);
    bus.src_data   = '0;
    bus.src_empty  = 4'hF;
    tick();
    bus.enable     = 1'($urandom);
    bus.src_mask   = 4'($urandom);
    bus.dst_full   = 1'($urandom);
    tick();
    check("rst_pop",   32'(bus.src_pop),    32'd0);
    check("rst_push",  32'(bus.dst_push),   32'd0);
    check("rst_data",  32'(bus.dst_data),   32'd0);
    check("rst_grant", 32'(bus.grant),      32'd3);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_count", 32'(bus.xfer_count), 32'd0);

    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.src_mask = 4'hF;
    bus.dst_full = 1'b0;
    tick();
    check("idle_empty", 32'(bus.busy), 32'd0);

    // Single source
    srcq[1].push_back(10'h011); srcq[1].push_back(10'h022); srcq[1].push_back(10'h033);
    expq.push_back(10'h011);    expq.push_back(10'h022);    expq.push_back(10'h033);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("single_pop",   32'(bus.src_pop),  32'h2);
      check("single_grant", 32'(bus.grant),    32'd1);
      tick();
      check("single_wait",  32'(bus.dst_push), 32'd0);
      tick();
      check("single_push",  32'(bus.dst_push), 32'd1);
    end
    tick();
    check("single_idle",  32'(bus.busy),       32'd0);
    check("single_count", 32'(bus.xfer_count), 32'd3);

    // Fairness from a clean reset: 0,0,1,1,2,2,3,3 twice
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 4; j++) srcq[s].push_back(10'(10'h200 + s*16 + j));
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++)
        for (int j = 2*r; j < 2*r + 2; j++) expq.push_back(10'(10'h200 + s*16 + j));
    pushes = 0;
    npop   = 0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (bus.src_pop != 4'b0000) begin
        exp_pop = 4'b0001 << ((npop / 2) % 4);
        check("fair_pop", 32'(bus.src_pop), 32'(exp_pop));
        npop++;
      end
      if (bus.dst_push) pushes++;
    end
    check("fair_pops",   32'(npop),   32'd16);
    check("fair_pushes", 32'(pushes), 32'd16);
    tick();
    check("fair_idle",  32'(bus.busy),       32'd0);
    check("fair_count", 32'(bus.xfer_count), 32'd16);

    // Backpressure
    bus.dst_full = 1'b1;
    srcq[0].push_back(10'h155);
    expq.push_back(10'h155);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_nopop", 32'(bus.src_pop), 32'd0);
    end
    check("bp_idle", 32'(bus.busy), 32'd0);
    bus.dst_full = 1'b0;
    tick();
    check("bp_pop", 32'(bus.src_pop), 32'h1);
    tick();
    tick();
    check("bp_push", 32'(bus.dst_push), 32'd1);
    tick();

    // Mask: source 2 excluded
    bus.src_mask = 4'b1011;
    srcq[0].push_back(10'h1A0);
    srcq[1].push_back(10'h1B0); srcq[1].push_back(10'h1B1);
    srcq[2].push_back(10'h1C0);
    srcq[3].push_back(10'h1D0);
    expq.push_back(10'h1A0); expq.push_back(10'h1B0);
    expq.push_back(10'h1B1); expq.push_back(10'h1D0);
    for (int c = 0; c < 13; c++) tick();
    check("mask_idle",  32'(bus.busy),          32'd0);
    check("mask_left",  32'(srcq[2].size()),    32'd1);
    check("mask_count", 32'(bus.xfer_count),    32'd21);
    srcq[2].delete();
    bus.src_mask = 4'hF;
    tick();

    // Enable dropped during WAIT
    srcq[3].push_back(10'h1E0); srcq[3].push_back(10'h1E1);
    expq.push_back(10'h1E0);
    tick();
    check("en_pop", 32'(bus.src_pop), 32'h8);
    tick();
    bus.enable = 1'b0;
    tick();
    check("en_push", 32'(bus.dst_push), 32'd1);
    tick();
    check("en_idle",  32'(bus.busy),    32'd0);
    check("en_nopop", 32'(bus.src_pop), 32'd0);
    tick();
    tick();
    check("en_still_idle", 32'(bus.busy), 32'd0);
    expq.push_back(10'h1E1);
    bus.enable = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("en_drain_idle", 32'(bus.busy),       32'd0);
    check("en_count",      32'(bus.xfer_count), 32'd23);

    // Reset in WAIT drops the in-flight word
    srcq[0].push_back(10'h0F0);
    srcq[1].push_back(10'h0F1);
    tick();
    check("mr_pop", 32'(bus.src_pop), 32'h1);
    tick();
    reset = 1'b0;
    tick();
    check("mr_nopush", 32'(bus.dst_push),   32'd0);
    check("mr_count",  32'(bus.xfer_count), 32'd0);
    check("mr_grant",  32'(bus.grant),      32'd3);
    check("mr_busy",   32'(bus.busy),       32'd0);
    reset = 1'b1;
    srcq[0].push_back(10'h0A5);
    expq.push_back(10'h0A5);
    expq.push_back(10'h0F1);
    tick();
    check("mr_first_src0", 32'(bus.src_pop), 32'h1);
    tick();
    tick();
    check("mr_push", 32'(bus.dst_push), 32'd1);
    tick();
    check("mr_second_src1", 32'(bus.src_pop), 32'h2);
    tick();
    tick();
    tick();
    check("mr_final_count", 32'(bus.xfer_count), 32'd2);
    check("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
